// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the coherence bus controller.
//   CPUS        - number of snooping dcaches served by the bus (two only)
//   word_t      - 32-bit data / address word
//   ramstate_t  - status reported by the RAM each cycle
//   bus_state_t - coherence bus controller states
package cpu_types_pkg;

  localparam int CPUS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE,
    SNOOP,
    C2C0,
    C2C1,
    RD0,
    RD1,
    WB0,
    WB1,
    DONE
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant.
//   clk, rst_n - clock, asynchronous active-low reset (priority -> 0)
//   req[1:0]   - request lines
//   advance    - pulse when a granted transaction completes; flips priority
//   grant      - index of the winning requester (only meaningful if |req)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic prio_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else if (advance) begin
      prio_reg <= ~prio_reg;
    end
  end

  // Favoured requester wins if it asks; otherwise the other one does.
  always_comb begin
    grant = req[prio_reg] ? prio_reg : ~prio_reg;
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: MSI-style snooping bus controller for two dcaches
// sharing one RAM port.
//   CLK, nRST            - clock, asynchronous active-low reset
//   dREN/dWEN/daddr/dstore, cctrans/ccwrite - per-cache requests / snoop responses
//   dwait/dload          - per-cache completion and read data
//   ccwait/ccinv/ccsnoopaddr - snoop request toward the non-requesting cache
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate - RAM port
// One transaction is in flight at a time; r is the granted cache and s=~r
// is the snooper. All outputs are combinational from state and r.
module coherence_bus_ctrl
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  word_t           daddr [CPUS],
  input  word_t           dstore [CPUS],
  input  logic [CPUS-1:0] cctrans,
  input  logic [CPUS-1:0] ccwrite,
  output logic [CPUS-1:0] dwait,
  output word_t           dload [CPUS],
  output logic [CPUS-1:0] ccwait,
  output logic [CPUS-1:0] ccinv,
  output word_t           ccsnoopaddr [CPUS],
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  bus_state_t      state_reg, state_next;
  logic            r_reg, r_next;
  logic            s_idx;
  logic            grant;
  logic            advance;
  logic            ram_done;
  logic [CPUS-1:0] req;

  for (genvar gi = 0; gi < CPUS; gi++) begin : g_req
    assign req[gi] = dREN[gi] | dWEN[gi] | cctrans[gi];
  end

  assign s_idx    = ~r_reg;
  // Only ACCESS completes a word; FREE, BUSY and ERROR all stall.
  assign ram_done = (ramstate == ACCESS);
  // Priority flips whenever any transaction hands the bus back.
  assign advance  = (state_reg != IDLE) && (state_next == IDLE);

  rr_arbiter2 u_arb (
    .clk     (CLK),
    .rst_n   (nRST),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      r_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    r_next      = r_reg;
    dwait       = '1;
    dload       = '{default: '0};
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '{default: '0};
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    unique case (state_reg)
      IDLE: begin
        if (|req) begin
          r_next = grant;
          if (cctrans[grant]) begin
            state_next = SNOOP;
          end else if (dWEN[grant]) begin
            state_next = WB0;
          end else begin
            state_next = RD0;
          end
        end
      end

      SNOOP: begin
        ccwait[s_idx]      = 1'b1;
        ccsnoopaddr[s_idx] = daddr[r_reg];
        ccinv[s_idx]       = ccwrite[r_reg];
        if (cctrans[s_idx]) begin
          if (ccwrite[s_idx]) begin
            state_next = C2C0;          // snooper owns the dirty block
          end else if (dREN[r_reg]) begin
            state_next = RD0;           // nobody supplies it: go to RAM
          end else begin
            state_next = DONE;          // upgrade: invalidation was enough
          end
        end
      end

      // Snooper's data goes to the requester and is written back at once.
      C2C0, C2C1: begin
        ccwait[s_idx] = 1'b1;
        ramWEN        = 1'b1;
        ramaddr       = daddr[s_idx];
        ramstore      = dstore[s_idx];
        dload[r_reg]  = dstore[s_idx];
        if (ram_done) begin
          dwait[r_reg] = 1'b0;
          dwait[s_idx] = 1'b0;
          if (state_reg == C2C0) begin
            state_next = C2C1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      RD0, RD1: begin
        ramREN       = 1'b1;
        ramaddr      = daddr[r_reg];
        dload[r_reg] = ramload;
        if (ram_done) begin
          dwait[r_reg] = 1'b0;
          if (state_reg == RD0) begin
            state_next = RD1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      WB0, WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_reg];
        ramstore = dstore[r_reg];
        if (ram_done) begin
          dwait[r_reg] = 1'b0;
          if (state_reg == WB0) begin
            state_next = WB1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DONE: begin
        dwait[r_reg] = 1'b0;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed scenarios for coherence_bus_ctrl with a
// transaction-level reference model compared against every output each cycle.
module tb_coherence_bus_ctrl;
  import cpu_types_pkg::*;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic [CPUS-1:0] dREN, dWEN, cctrans, ccwrite;
  logic [CPUS-1:0] dwait, ccwait, ccinv;
  word_t           daddr [CPUS];
  word_t           dstore [CPUS];
  word_t           dload [CPUS];
  word_t           ccsnoopaddr [CPUS];
  logic            ramREN, ramWEN;
  word_t           ramaddr, ramstore, ramload;
  ramstate_t       ramstate;

  coherence_bus_ctrl dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .cctrans     (cctrans),
    .ccwrite     (ccwrite),
    .dwait       (dwait),
    .dload       (dload),
    .ccwait      (ccwait),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (ramstate)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int strobes = 0;
  int txn_count = 0;
  word_t mem [word_t];

  // Reference model: what transaction is in progress, who owns it, which word.
  localparam int K_IDLE = 0, K_SNOOP = 1, K_C2C = 2, K_RD = 3, K_WB = 4, K_ACK = 5;
  int m_kind = K_IDLE;
  int m_word = 0;
  int m_r = 0;
  int m_prio = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk(input string name, input word_t act, input word_t exp);
    check(name, 256'(act), 256'(exp));
  endtask

  function automatic word_t mem_rd(input word_t a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic finish_txn();
    string kname;
    case (m_kind)
      K_C2C:   kname = "cache-to-cache";
      K_RD:    kname = "read";
      K_WB:    kname = "writeback";
      default: kname = "upgrade";
    endcase
    txn_count++;
    $display("txn %0d: cache%0d %s complete", txn_count, m_r, kname);
    m_kind = K_IDLE;
    m_prio = 1 - m_prio;
  endtask

  // Advance the model by one clock using the inputs the DUT will sample.
  task automatic model_step();
    logic [1:0] req;
    int s;
    s = 1 - m_r;
    case (m_kind)
      K_IDLE: begin
        req = dREN | dWEN | cctrans;
        if (req != 2'b00) begin
          m_r    = req[m_prio] ? m_prio : 1 - m_prio;
          m_kind = cctrans[m_r] ? K_SNOOP : (dWEN[m_r] ? K_WB : K_RD);
          m_word = 0;
        end
      end
      K_SNOOP: if (cctrans[s]) m_kind = ccwrite[s] ? K_C2C : (dREN[m_r] ? K_RD : K_ACK);
      K_C2C, K_RD, K_WB: begin
        if (ramstate == ACCESS) begin
          if (m_word == 1) finish_txn();
          else m_word = 1;
        end
      end
      K_ACK: finish_txn();
      default: ;
    endcase
  endtask

  task automatic compare_outputs();
    logic [1:0] e_dwait, e_ccwait, e_ccinv;
    logic  e_ren, e_wen;
    word_t e_addr, e_store;
    word_t e_dl [CPUS];
    word_t e_sa [CPUS];
    int s;
    e_dwait = 2'b11; e_ccwait = 2'b00; e_ccinv = 2'b00;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    e_dl = '{default: '0}; e_sa = '{default: '0};
    s = 1 - m_r;
    case (m_kind)
      K_SNOOP: begin
        e_ccwait[s] = 1'b1; e_sa[s] = daddr[m_r]; e_ccinv[s] = ccwrite[m_r];
      end
      K_C2C: begin
        e_ccwait[s] = 1'b1; e_wen = 1'b1; e_addr = daddr[s]; e_store = dstore[s];
        e_dl[m_r] = dstore[s];
        if (ramstate == ACCESS) e_dwait = 2'b00;
      end
      K_RD: begin
        e_ren = 1'b1; e_addr = daddr[m_r]; e_dl[m_r] = ramload;
        if (ramstate == ACCESS) e_dwait[m_r] = 1'b0;
      end
      K_WB: begin
        e_wen = 1'b1; e_addr = daddr[m_r]; e_store = dstore[m_r];
        if (ramstate == ACCESS) e_dwait[m_r] = 1'b0;
      end
      K_ACK: e_dwait[m_r] = 1'b0;
      default: ;
    endcase
    check("bus_outputs",
          256'({dwait, ccwait, ccinv, ramREN, ramWEN, ramaddr, ramstore,
                dload[0], dload[1], ccsnoopaddr[0], ccsnoopaddr[1]}),
          256'({e_dwait, e_ccwait, e_ccinv, e_ren, e_wen, e_addr, e_store,
                e_dl[0], e_dl[1], e_sa[0], e_sa[1]}));
  endtask

  // Compare process: outputs are settled and inputs stable at the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        m_kind = K_IDLE; m_word = 0; m_r = 0; m_prio = 0;
      end
      compare_outputs();
      if (nRST) begin
        if (ramREN || ramWEN) strobes++;
        if (ramWEN && ramstate == ACCESS) mem[ramaddr] = ramstore;
        model_step();
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    ramstate = FREE; ramload = '0;
  endtask

  // Cache c is in a RAM read; each word waits n_busy BUSY cycles then ACCESS.
  // Ends at the drive point of the following IDLE cycle with dREN[c] dropped.
  task automatic rd_words(input int c, input word_t a, input int n_busy,
                          input word_t d0, input word_t d1);
    word_t d [2];
    d[0] = d0; d[1] = d1;
    for (int w = 0; w < 2; w++) begin
      daddr[c] = a + 32'(4 * w);
      ramstate = BUSY;
      for (int b = 0; b < n_busy; b++) begin
        #1;
        chk("rd_busy_dwait", 32'(dwait[c]), 32'd1);
        cycle();
      end
      ramstate = ACCESS; ramload = d[w];
      #1;
      chk("rd_dload", dload[c], d[w]);
      chk("rd_dwait_low", 32'(dwait[c]), 32'd0);
      cycle();
    end
    dREN[c] = 1'b0; ramstate = FREE; ramload = '0;
  endtask

  int s0;

  initial begin
    clear_inputs();
    daddr = '{default: '0}; dstore = '{default: '0};
    #2;
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_ramstrobe", 32'({ramREN, ramWEN}), 32'h0);
    chk("rst_ccwait", 32'(ccwait), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    cycle(); cycle();
    nRST = 1'b1;

    // Contention right after reset: cache0 first, then cache1, tie again -> cache0.
    dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600;
    cycle(); #1;
    chk("tie1_grant_addr", ramaddr, 32'h500);
    chk("tie1_loser_wait", 32'(dwait[1]), 32'd1);
    rd_words(0, 32'h500, 0, 32'h11, 32'h22);
    cycle(); #1;
    chk("tie1_second_addr", ramaddr, 32'h600);
    rd_words(1, 32'h600, 0, 32'h33, 32'h44);
    dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600;
    cycle(); #1;
    chk("tie2_grant_addr", ramaddr, 32'h500);
    rd_words(0, 32'h500, 0, 32'h55, 32'h66);
    cycle();
    rd_words(1, 32'h600, 0, 32'h77, 32'h88);

    // Upgrade: cache0 BusRdX-less invalidate of 0x100, snooper answers next cycle.
    s0 = strobes;
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h100;
    cycle();
    cctrans[1] = 1'b1; #1;
    chk("upg_ccinv1", 32'(ccinv[1]), 32'd1);
    chk("upg_snoopaddr1", ccsnoopaddr[1], 32'h100);
    chk("upg_ccwait", 32'(ccwait), 32'h2);
    chk("upg_wait_c2", 32'(dwait[0]), 32'd1);
    cycle();
    clear_inputs(); #1;
    chk("upg_dwait0_c3", 32'(dwait[0]), 32'd0);
    cycle(); #1;
    chk("upg_dwait0_after", 32'(dwait[0]), 32'd1);
    chk("upg_no_ram", 32'(strobes - s0), 32'd0);

    // Cache-to-cache: cache1 reads 0x200, cache0 holds it Modified.
    cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h200;
    cycle();
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'hDEAD; #1;
    chk("c2c_snoopaddr0", ccsnoopaddr[0], 32'h200);
    chk("c2c_ccinv0", 32'(ccinv[0]), 32'd0);
    cycle();
    ramstate = BUSY; #1;
    chk("c2c_busy_wait", 32'(dwait), 32'h3);
    cycle();
    ramstate = ACCESS; #1;
    chk("c2c_dload_w0", dload[1], 32'hDEAD);
    chk("c2c_dwait_w0", 32'(dwait), 32'h0);
    cycle();
    daddr[0] = 32'h204; daddr[1] = 32'h204; dstore[0] = 32'hBEEF; #1;
    chk("c2c_dload_w1", dload[1], 32'hBEEF);
    chk("c2c_ramaddr_w1", ramaddr, 32'h204);
    cycle();
    clear_inputs(); #1;
    chk("c2c_mem_200", mem_rd(32'h200), 32'hDEAD);
    chk("c2c_mem_204", mem_rd(32'h204), 32'hBEEF);

    // Miss with no supplier: cache0 reads 0x400 from RAM, two BUSY cycles per word.
    cctrans[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h400;
    cycle();
    cctrans[1] = 1'b1; #1;
    chk("miss_ccinv1", 32'(ccinv[1]), 32'd0);
    cycle();
    cctrans = '0;
    rd_words(0, 32'h400, 2, 32'h1234, 32'h5678);

    // Writeback: cache1 writes 0x300/0x304, ERROR stalls it.
    dWEN[1] = 1'b1; daddr[1] = 32'h300; dstore[1] = 32'hC0DE0000;
    cycle();
    ramstate = ERROR;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wb_error_hold", 32'(dwait[1]), 32'd1);
      chk("wb_no_snoop", 32'(ccwait), 32'h0);
      cycle();
    end
    ramstate = ACCESS; #1;
    chk("wb_wen_w0", 32'({ramREN, ramWEN}), 32'h1);
    chk("wb_dwait_w0", 32'(dwait[1]), 32'd0);
    cycle();
    daddr[1] = 32'h304; dstore[1] = 32'hC0DE0001; #1;
    chk("wb_dwait_w1", 32'(dwait[1]), 32'd0);
    cycle();
    clear_inputs(); #1;
    chk("wb_mem_300", mem_rd(32'h300), 32'hC0DE0000);
    chk("wb_mem_304", mem_rd(32'h304), 32'hC0DE0001);

    // Reset in the middle of the second cache-to-cache word.
    cctrans[1] = 1'b1; dREN[1] = 1'b1; daddr[1] = 32'h800;
    cycle();
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h800; dstore[0] = 32'h0A0A;
    cycle();
    ramstate = ACCESS;
    cycle();
    ramstate = BUSY; #1;
    chk("c2c1_before_rst", 32'(ramWEN), 32'd1);
    nRST = 1'b0; #1;
    chk("midrst_dwait", 32'(dwait), 32'h3);
    chk("midrst_ramstrobe", 32'({ramREN, ramWEN}), 32'h0);
    chk("midrst_ccwait", 32'(ccwait), 32'h0);
    chk("midrst_dload1", dload[1], 32'h0);
    chk("midrst_ramaddr", ramaddr, 32'h0);
    clear_inputs();
    cycle();
    nRST = 1'b1;
    dREN[0] = 1'b1; daddr[0] = 32'h700;
    cycle(); #1;
    chk("post_rst_addr", ramaddr, 32'h700);
    chk("post_rst_ren", 32'(ramREN), 32'd1);
    rd_words(0, 32'h700, 1, 32'h77, 32'h78);
    cycle(); cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
